// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped, one-word-line data cache.
// Default geometry: 32-bit data, 32-bit byte address, 8 sets.
package cache_pkg;

   localparam int unsigned CACHE_DATA_WIDTH = 32;
   localparam int unsigned CACHE_ADDR_WIDTH = 32;
   localparam int unsigned CACHE_SET_BITS   = 3;
   localparam int unsigned CACHE_NUM_SETS   = 1 << CACHE_SET_BITS;
   localparam int unsigned CACHE_TAG_BITS   = CACHE_ADDR_WIDTH - CACHE_SET_BITS - 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEM_RD = 2'd1,
      MEM_WR = 2'd2
   } cache_state_t;

   typedef struct packed {
      logic                        valid;
      logic [CACHE_TAG_BITS-1:0]   tag;
      logic [CACHE_DATA_WIDTH-1:0] data;
   } cache_line_t;

   // Set index of a byte address (word offset bits [1:0] skipped).
   function automatic logic [CACHE_SET_BITS-1:0] addr_set(input logic [CACHE_ADDR_WIDTH-1:0] addr);
      return addr[CACHE_SET_BITS+1:2];
   endfunction

   // Tag of a byte address (everything above the set index).
   function automatic logic [CACHE_TAG_BITS-1:0] addr_tag(input logic [CACHE_ADDR_WIDTH-1:0] addr);
      return addr[CACHE_ADDR_WIDTH-1:CACHE_SET_BITS+2];
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data line array for the data cache.
// One combinational read port by set, one write port, synchronous clear-all
// of the valid bits and asynchronous reset of the valid bits.
module cache_line_store #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_BITS   = 27,
   parameter int SET_BITS   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic [SET_BITS-1:0]   rd_set_i,
   output logic                  rd_valid_o,
   output logic [TAG_BITS-1:0]   rd_tag_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   input  logic                  wr_en_i,
   input  logic [SET_BITS-1:0]   wr_set_i,
   input  logic [TAG_BITS-1:0]   wr_tag_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i
);

   localparam int NUM_SETS = 1 << SET_BITS;

   logic [NUM_SETS-1:0]   valid_q;
   logic [TAG_BITS-1:0]   tag_q  [NUM_SETS];
   logic [DATA_WIDTH-1:0] data_q [NUM_SETS];

   // Valid bits: cleared by reset or flush, set when a line is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= {NUM_SETS{1'b0}};
      end else if (clear_i) begin
         valid_q <= {NUM_SETS{1'b0}};
      end else if (wr_en_i) begin
         valid_q[wr_set_i] <= 1'b1;
      end else begin
         valid_q <= valid_q;
      end
   end

   // Tag and data payload; meaningless while the valid bit is clear, so not reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_set_i]  <= wr_tag_i;
         data_q[wr_set_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_set_i];
   assign rd_tag_o   = tag_q[rd_set_i];
   assign rd_data_o  = data_q[rd_set_i];

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for the direct-mapped, one-word-line, write-through,
// no-write-allocate data cache. Read hits answer in the same cycle; read misses
// refill over a req/ack handshake; every store is written through to memory.
// Optional feature macro: CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int SET_BITS      = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,
   output logic                     cpu_stall,
   input  logic                     flush,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   input  logic                     mem_ack
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]              hit_count,
   output logic [31:0]              miss_count
`endif
);

   localparam int TAG_BITS = ADDRESS_WIDTH - SET_BITS - 2;

   cache_state_t             state_q;
   logic                     mem_req_q;
   logic                     mem_we_q;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0]    mem_wdata_q;

   logic [SET_BITS-1:0]      cpu_set_s;
   logic [TAG_BITS-1:0]      cpu_tag_s;
   logic [SET_BITS-1:0]      lat_set_s;
   logic [TAG_BITS-1:0]      lat_tag_s;
   logic [SET_BITS-1:0]      rd_set_s;
   logic                     rd_valid_s;
   logic [TAG_BITS-1:0]      rd_tag_s;
   logic [DATA_WIDTH-1:0]    rd_data_s;
   logic                     cpu_hit_s;
   logic                     lat_hit_s;
   logic                     clear_s;
   logic                     line_we_s;
   logic [DATA_WIDTH-1:0]    line_wdata_s;
   logic                     addr_lsb_unused_s;

   // Byte offset within the word never affects a word-sized access.
   assign addr_lsb_unused_s = ^cpu_addr[1:0];

   assign cpu_set_s = cpu_addr[SET_BITS+1:2];
   assign cpu_tag_s = cpu_addr[ADDRESS_WIDTH-1:SET_BITS+2];
   assign lat_set_s = mem_addr_q[SET_BITS+1:2];
   assign lat_tag_s = mem_addr_q[ADDRESS_WIDTH-1:SET_BITS+2];

   // While a memory access is outstanding the CPU address may wander, so the
   // line store is looked up with the latched address instead.
   assign rd_set_s  = (state_q == IDLE) ? cpu_set_s : lat_set_s;
   assign cpu_hit_s = rd_valid_s && (rd_tag_s == cpu_tag_s);
   assign lat_hit_s = rd_valid_s && (rd_tag_s == lat_tag_s);

   cache_line_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_BITS   (TAG_BITS),
      .SET_BITS   (SET_BITS)
   ) u_lines (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (clear_s),
      .rd_set_i   (rd_set_s),
      .rd_valid_o (rd_valid_s),
      .rd_tag_o   (rd_tag_s),
      .rd_data_o  (rd_data_s),
      .wr_en_i    (line_we_s),
      .wr_set_i   (lat_set_s),
      .wr_tag_i   (lat_tag_s),
      .wr_data_i  (line_wdata_s)
   );

   // CPU-facing stall/read data and line-store write/clear control.
   always_comb begin
      cpu_stall    = 1'b0;
      cpu_rdata    = {DATA_WIDTH{1'b0}};
      clear_s      = 1'b0;
      line_we_s    = 1'b0;
      line_wdata_s = mem_rdata;
      case (state_q)
         IDLE: begin
            if (flush) begin
               clear_s   = 1'b1;
               cpu_stall = cpu_req;
            end else if (cpu_req && !cpu_we) begin
               if (cpu_hit_s) begin
                  cpu_rdata = rd_data_s;
               end else begin
                  cpu_stall = 1'b1;
               end
            end else if (cpu_req) begin
               cpu_stall = 1'b1;
            end else begin
               cpu_stall = 1'b0;
            end
         end
         MEM_RD: begin
            cpu_stall = !mem_ack;
            if (mem_ack) begin
               cpu_rdata    = mem_rdata;
               line_we_s    = 1'b1;
               line_wdata_s = mem_rdata;
            end else begin
               line_we_s = 1'b0;
            end
         end
         MEM_WR: begin
            cpu_stall = !mem_ack;
            if (mem_ack && lat_hit_s) begin
               line_we_s    = 1'b1;
               line_wdata_s = mem_wdata_q;
            end else begin
               line_we_s = 1'b0;
            end
         end
         default: begin
            cpu_stall = 1'b0;
         end
      endcase
   end

   // Access sequencer: decodes CPU requests in IDLE and owns the registered memory port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDRESS_WIDTH{1'b0}};
         mem_wdata_q <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (!flush && cpu_req) begin
                  if (cpu_we) begin
                     mem_addr_q  <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                     mem_wdata_q <= cpu_wdata;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     state_q     <= MEM_WR;
                  end else if (!cpu_hit_s) begin
                     mem_addr_q  <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b0;
                     state_q     <= MEM_RD;
                  end
               end
            end
            MEM_RD, MEM_WR: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
   logic        idle_read_s;
   logic [31:0] hit_count_q;
   logic [31:0] hit_count_d;
   logic [31:0] miss_count_q;
   logic [31:0] miss_count_d;

   assign idle_read_s = (state_q == IDLE) && !flush && cpu_req && !cpu_we;

   // Each IDLE read decision bumps exactly one saturating counter.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (idle_read_s && cpu_hit_s) begin
         if (hit_count_q != 32'hFFFF_FFFF) begin
            hit_count_d = hit_count_q + 32'd1;
         end else begin
            hit_count_d = hit_count_q;
         end
      end else if (idle_read_s) begin
         if (miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
         end else begin
            miss_count_d = miss_count_q;
         end
      end else begin
         hit_count_d  = hit_count_q;
         miss_count_d = miss_count_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios followed by random
// loads/stores/flushes, scored against a line-level cache model and a word memory.
// Build with +define+CACHE_STATS_EN to also score the hit/miss counters.
module tb_cache_ctrl;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        flush;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   cache_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
`ifdef CACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: cache contents, backing memory, expected statistics.
   cache_line_t model_lines [CACHE_NUM_SETS];
   logic [31:0] mem_model [logic [31:0]];
   int          exp_hits;
   int          exp_misses;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] word);
      if (mem_model.exists(word)) return mem_model[word];
      return word ^ 32'h5A5A_A5A5;
   endfunction

   task automatic model_invalidate();
      for (int i = 0; i < CACHE_NUM_SETS; i++) model_lines[i].valid = 1'b0;
   endtask

   task automatic check_stats();
`ifdef CACHE_STATS_EN
      check_val("hit_count", hit_count, 32'(exp_hits));
      check_val("miss_count", miss_count, 32'(exp_misses));
`endif
   endtask

   // One complete CPU access, acting as the memory when traffic is expected.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input logic scramble);
      logic [CACHE_SET_BITS-1:0] set;
      logic [CACHE_TAG_BITS-1:0] tag;
      logic [31:0]               word;
      logic [31:0]               rdv;
      logic                      hit;
      set  = addr_set(addr);
      tag  = addr_tag(addr);
      word = {addr[31:2], 2'b00};
      rdv  = mem_read(word);
      hit  = !we && model_lines[set].valid && (model_lines[set].tag == tag);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; flush = 1'b0;
      @(negedge clk);
      check_val("decode_stall", 32'(cpu_stall), hit ? 32'd0 : 32'd1);
      check_val("decode_no_mem_req", 32'(mem_req), 32'd0);
      if (hit) begin
         check_val("hit_rdata", cpu_rdata, model_lines[set].data);
         exp_hits++;
      end else if (!we) begin
         exp_misses++;
      end
      @(posedge clk); #1;
      if (!hit) begin
         for (int c = 1; c <= lat; c++) begin
            if (scramble) begin
               cpu_addr  = $urandom;
               cpu_we    = 1'($urandom_range(0, 1));
               cpu_wdata = $urandom;
               flush     = 1'($urandom_range(0, 1));
            end
            mem_rdata = $urandom;
            if (c == lat) begin
               mem_ack = 1'b1;
               if (!we) mem_rdata = rdv;
            end
            @(negedge clk);
            check_val("mem_req", 32'(mem_req), 32'd1);
            check_val("mem_we", 32'(mem_we), 32'(we));
            check_val("mem_addr", mem_addr, word);
            if (we) check_val("mem_wdata", mem_wdata, wdata);
            check_val("busy_stall", 32'(cpu_stall), (c == lat) ? 32'd0 : 32'd1);
            if (c == lat && !we) check_val("refill_bypass", cpu_rdata, rdv);
            @(posedge clk); #1;
            mem_ack = 1'b0;
         end
         if (we) begin
            mem_model[word] = wdata;
            if (model_lines[set].valid && model_lines[set].tag == tag) model_lines[set].data = wdata;
         end else begin
            model_lines[set] = '{valid: 1'b1, tag: tag, data: rdv};
         end
      end
      cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0;
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("idle_mem_req", 32'(mem_req), 32'd0);
      check_val("idle_stall", 32'(cpu_stall), 32'd0);
      check_val("idle_rdata", cpu_rdata, 32'd0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic do_flush(input logic with_req, input logic [31:0] addr);
      cpu_req = with_req; cpu_we = 1'b0; cpu_addr = addr; flush = 1'b1;
      @(negedge clk);
      check_val("flush_stall", 32'(cpu_stall), 32'(with_req));
      @(posedge clk); #1;
      flush = 1'b0; cpu_req = 1'b0;
      model_invalidate();
      @(negedge clk);
      check_val("flush_no_traffic", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      flush = 1'b0; mem_rdata = 32'd0; mem_ack = 1'b0;
      model_invalidate();
      exp_hits = 0; exp_misses = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_mem_req", 32'(mem_req), 32'd0);
      check_val("rst_mem_we", 32'(mem_we), 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'd0);
      check_val("rst_mem_wdata", mem_wdata, 32'd0);
      check_val("rst_stall", 32'(cpu_stall), 32'd0);
      check_val("rst_rdata", cpu_rdata, 32'd0);
      check_stats();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      mem_model[32'h10] = 32'hDEAD_BEEF;
      mem_model[32'h30] = 32'hCAFE_F00D;

      // Scenario 1: miss with refill, then same-cycle hit.
      access(1'b0, 32'h10, 32'd0, 3, 1'b0);
      access(1'b0, 32'h10, 32'd0, 1, 1'b0);
      check_stats();
      // Scenario 2: conflicting tag in set 4 replaces the line.
      access(1'b0, 32'h30, 32'd0, 2, 1'b0);
      access(1'b0, 32'h10, 32'd0, 2, 1'b0);
      // Scenario 3: write-through on a hit updates the line.
      access(1'b1, 32'h10, 32'h1234_5678, 2, 1'b0);
      access(1'b0, 32'h10, 32'd0, 1, 1'b0);
      // Scenario 4: store to an invalid set does not allocate.
      do_flush(1'b0, 32'd0);
      access(1'b1, 32'h50, 32'hA5A5_A5A5, 1, 1'b0);
      access(1'b0, 32'h50, 32'd0, 2, 1'b0);
      // Scenario 5: flush alone, then flush together with a request.
      access(1'b0, 32'h10, 32'd0, 1, 1'b0);
      do_flush(1'b0, 32'd0);
      access(1'b0, 32'h10, 32'd0, 1, 1'b0);
      do_flush(1'b1, 32'h10);
      access(1'b0, 32'h10, 32'd0, 1, 1'b0);
      check_stats();

      // Scenario 6: reset aborts an outstanding refill.
      do_flush(1'b0, 32'd0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      @(posedge clk); #1;
      @(negedge clk);
      check_val("refill_started", 32'(mem_req), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_val("rst_abort_mem_req", 32'(mem_req), 32'd0);
      cpu_req = 1'b0;
      model_invalidate();
      exp_hits = 0; exp_misses = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_stats();
      access(1'b0, 32'h10, 32'd0, 2, 1'b0);
      access(1'b0, 32'h10, 32'd0, 1, 1'b0);

      // Random mix over 4 tags x 8 sets with random byte offsets.
      for (int i = 0; i < 400; i++) begin
         a = 32'($urandom_range(0, 127));
         r = $urandom_range(0, 99);
         if (r < 5) do_flush(1'(r < 2), a);
         else access(1'(r < 35), a, $urandom, $urandom_range(1, 4), 1'b1);
      end
      check_stats();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
